// File: rtl/sized_data_memory_if.sv
// Request/response bus of the sized data memory.
// master = load/store unit side, slave = memory side.
interface sized_data_memory_if #(
  parameter int DATAWIDTH = 32,
  parameter int AW        = 14
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [1:0]           req_size_i;
  logic                 req_unsigned_i;
  logic [AW-1:0]        req_addr_i;
  logic [DATAWIDTH-1:0] req_wdata_i;
  logic                 rsp_valid_o;
  logic [DATAWIDTH-1:0] rsp_rdata_o;
  logic                 rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i,
    output req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i,
    input  req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/sized_data_memory.sv
// Byte-addressed single-port data memory with sized, extended loads,
// error responses and a post-reset clear sweep.
module sized_data_memory #(
  parameter int NUMWORDS  = 4096,
  parameter int DATAWIDTH = 32,
  parameter int LATENCY   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sized_data_memory_if.slave bus
);
  localparam int NB  = DATAWIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(NUMWORDS);
  localparam int AW  = IW + OFF;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state;
  logic [IW-1:0]        clr_cnt;
  logic                 ready_q;
  logic [DATAWIDTH-1:0] mem [NUMWORDS];

  logic                 accept;
  logic [IW-1:0]        word;
  logic [OFF-1:0]       lane;
  logic                 big;
  logic                 misal;
  logic                 err;
  logic                 st_en;
  logic [NB-1:0]        be_base;
  logic [NB-1:0]        be;
  logic [DATAWIDTH-1:0] wsh;

  assign accept = bus.req_valid_i & ready_q;
  assign word   = bus.req_addr_i[AW-1:OFF];
  assign lane   = bus.req_addr_i[OFF-1:0];
  assign big    = int'(bus.req_size_i) > OFF;
  assign misal  = |(lane &
                   OFF'((4'd1 << bus.req_size_i) - 4'd1));
  assign err    = big | misal;
  assign st_en  = accept & bus.req_we_i & ~err;
  assign wsh    = bus.req_wdata_i << {lane, 3'b000};
  assign be     = be_base << lane;

  always_comb begin
    be_base = '1;
    case (bus.req_size_i)
      2'd0:    be_base = NB'(8'h01);
      2'd1:    be_base = NB'(8'h03);
      2'd2:    be_base = NB'(8'h0f);
      default: be_base = '1;
    endcase
  end

  // Array has no reset so it maps onto RAM; the sweep zeroes it.
  logic [DATAWIDTH-1:0] rd_word;

  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (st_en) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[word][8*b +: 8] <= wsh[8*b +: 8];
    end
    rd_word <= mem[word];
  end

  logic           v1;
  logic           err1;
  logic           we1;
  logic [1:0]     size1;
  logic           uns1;
  logic [OFF-1:0] lane1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      v1      <= 1'b0;
      err1    <= 1'b0;
      we1     <= 1'b0;
      size1   <= '0;
      uns1    <= 1'b0;
      lane1   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IW'(NUMWORDS - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: ready_q <= 1'b1;
      endcase
      v1 <= accept;
      if (accept) begin
        err1  <= err;
        we1   <= bus.req_we_i;
        size1 <= bus.req_size_i;
        uns1  <= bus.req_unsigned_i;
        lane1 <= lane;
      end
    end
  end

  logic [DATAWIDTH-1:0] shifted;
  logic [DATAWIDTH-1:0] mask;
  logic                 sbit;
  logic [DATAWIDTH-1:0] fmt;
  logic [DATAWIDTH-1:0] res_data;
  logic                 res_err;

  always_comb begin
    shifted = rd_word >> {lane1, 3'b000};
    mask    = '1;
    sbit    = shifted[DATAWIDTH-1];
    case (size1)
      2'd0: begin
        mask = DATAWIDTH'(8'hff);
        sbit = shifted[7];
      end
      2'd1: begin
        mask = DATAWIDTH'(16'hffff);
        sbit = shifted[15];
      end
      2'd2: begin
        mask = DATAWIDTH'(32'hffff_ffff);
        sbit = shifted[31];
      end
      default: ;
    endcase
    fmt = (shifted & mask) |
          ((sbit & ~uns1) ? ~mask : '0);
  end

  assign res_data = (v1 & ~err1 & ~we1) ? fmt : '0;
  assign res_err  = v1 & err1;
  assign bus.req_ready_o = ready_q;

  if (LATENCY == 2) begin : g_lat2
    logic                 v2;
    logic [DATAWIDTH-1:0] d2;
    logic                 e2;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        v2 <= 1'b0;
        d2 <= '0;
        e2 <= 1'b0;
      end else begin
        v2 <= v1;
        d2 <= res_data;
        e2 <= res_err;
      end
    end

    assign bus.rsp_valid_o = v2;
    assign bus.rsp_rdata_o = d2;
    assign bus.rsp_err_o   = e2;
  end else begin : g_lat1
    assign bus.rsp_valid_o = v1;
    assign bus.rsp_rdata_o = res_data;
    assign bus.rsp_err_o   = res_err;
  end
endmodule

// File: tb/tb_sized_data_memory.sv
// Bench: byte-array model checked every cycle against LATENCY 1 and 2
// instances; a 64-bit instance covers double accesses.
module tb_sized_data_memory;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   rel = 0;
  bit   started = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sized_data_memory_if #(.DATAWIDTH(32), .AW(6)) b1 ();
  sized_data_memory_if #(.DATAWIDTH(32), .AW(6)) b2 ();
  sized_data_memory_if #(.DATAWIDTH(64), .AW(7)) b3 ();

  assign b2.req_valid_i    = b1.req_valid_i;
  assign b2.req_we_i       = b1.req_we_i;
  assign b2.req_size_i     = b1.req_size_i;
  assign b2.req_unsigned_i = b1.req_unsigned_i;
  assign b2.req_addr_i     = b1.req_addr_i;
  assign b2.req_wdata_i    = b1.req_wdata_i;

  sized_data_memory #(.NUMWORDS(16), .DATAWIDTH(32), .LATENCY(1))
    u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  sized_data_memory #(.NUMWORDS(16), .DATAWIDTH(32), .LATENCY(2))
    u2 (.clk_i(clk), .rst_i(rst), .bus(b2));
  sized_data_memory #(.NUMWORDS(16), .DATAWIDTH(64), .LATENCY(1))
    u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [7:0] mb [64];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, want, cyc);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] sz,
                       input logic un, input logic [5:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    e = (n > 4) || ((int'(a) % n) != 0);
    d = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v = v | (64'(mb[int'(a) + i]) << (8 * i));
        if (!un && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        d = v[31:0];
      end
    end
  endtask

  task automatic req(input logic we, input logic [1:0] sz,
                     input logic un, input logic [5:0] a,
                     input logic [31:0] wd,
                     output logic [31:0] d, output logic e);
    exp_t x;
    @(negedge clk);
    b1.req_valid_i    = 1'b1;
    b1.req_we_i       = we;
    b1.req_size_i     = sz;
    b1.req_unsigned_i = un;
    b1.req_addr_i     = a;
    b1.req_wdata_i    = wd;
    chk("accept", 64'(b1.req_ready_o), 64'd1);
    model(we, sz, un, a, wd, d, e);
    if (b1.req_ready_o) begin
      x.due = cyc + 1;
      x.d = d;
      x.e = e;
      q1.push_back(x);
      x.due = cyc + 2;
      q2.push_back(x);
    end
    @(posedge clk);
    #1 b1.req_valid_i = 1'b0;
  endtask

  task automatic req64(input logic we, input logic [1:0] sz,
                       input logic un, input logic [6:0] a,
                       input logic [63:0] wd,
                       output logic [63:0] d, output logic [1:0] ve);
    @(negedge clk);
    b3.req_valid_i    = 1'b1;
    b3.req_we_i       = we;
    b3.req_size_i     = sz;
    b3.req_unsigned_i = un;
    b3.req_addr_i     = a;
    b3.req_wdata_i    = wd;
    chk("accept64", 64'(b3.req_ready_o), 64'd1);
    @(posedge clk);
    #1 b3.req_valid_i = 1'b0;
    @(negedge clk);
    d  = b3.rsp_rdata_o;
    ve = {b3.rsp_valid_o, b3.rsp_err_o};
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!b1.req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(n), 64'd16);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q1.delete();
    q2.delete();
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
  endtask

  // Per-cycle comparison of both 32-bit instances against the model.
  always @(negedge clk) begin : cmp
    logic        rdy;
    logic [33:0] w;
    exp_t        x;
    if (started) begin
      rdy = !rst && (cyc >= rel + 16);
      chk("ready_l1", 64'(b1.req_ready_o), 64'(rdy));
      chk("ready_l2", 64'(b2.req_ready_o), 64'(rdy));
      w = '0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
        x = q1.pop_front();
        w = {1'b1, x.e, x.d};
      end
      chk("rsp_l1", 64'({b1.rsp_valid_o, b1.rsp_err_o, b1.rsp_rdata_o}),
          64'(w));
      w = '0;
      if (q2.size() > 0 && q2[0].due == cyc) begin
        x = q2.pop_front();
        w = {1'b1, x.e, x.d};
      end
      chk("rsp_l2", 64'({b2.rsp_valid_o, b2.rsp_err_o, b2.rsp_rdata_o}),
          64'(w));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [63:0] d64;
    logic [1:0]  ve;
    b1.req_valid_i = 1'b0;
    b1.req_we_i = 1'b0;
    b1.req_size_i = 2'd0;
    b1.req_unsigned_i = 1'b0;
    b1.req_addr_i = '0;
    b1.req_wdata_i = '0;
    b3.req_valid_i = 1'b0;
    b3.req_we_i = 1'b0;
    b3.req_size_i = 2'd0;
    b3.req_unsigned_i = 1'b0;
    b3.req_addr_i = '0;
    b3.req_wdata_i = '0;
    #2;
    @(negedge clk);
    chk("rst_rdy", 64'(b1.req_ready_o), 64'd0);
    chk("rst_rsp", 64'({b1.rsp_valid_o, b1.rsp_err_o, b1.rsp_rdata_o}), 64'd0);
    do_reset();
    started = 1'b1;
    chk("rst_rdy2", 64'(b1.req_ready_o), 64'd0);
    wait_ready("clr_len");

    req(0, 2, 0, 6'h14, 0, d, e);
    chk("t1_ld", 64'({e, d}), 64'h0);

    req(1, 2, 0, 6'h10, 32'hDEADBEEF, d, e);
    req(0, 0, 0, 6'h10, 0, d, e); chk("t2_b0", 64'(d), 64'hFFFFFFEF);
    req(0, 0, 0, 6'h11, 0, d, e); chk("t2_b1", 64'(d), 64'hFFFFFFBE);
    req(0, 0, 0, 6'h12, 0, d, e); chk("t2_b2", 64'(d), 64'hFFFFFFAD);
    req(0, 0, 0, 6'h13, 0, d, e); chk("t2_b3", 64'(d), 64'hFFFFFFDE);
    req(0, 0, 1, 6'h13, 0, d, e); chk("t2_ub3", 64'(d), 64'h000000DE);

    req(1, 2, 0, 6'h20, 32'h11223344, d, e);
    req(1, 1, 0, 6'h22, 32'h00008001, d, e);
    req(0, 2, 0, 6'h20, 0, d, e); chk("t3_w", 64'(d), 64'h80013344);
    req(0, 1, 0, 6'h22, 0, d, e); chk("t3_sh", 64'(d), 64'hFFFF8001);
    req(0, 1, 1, 6'h22, 0, d, e); chk("t3_uh", 64'(d), 64'h00008001);

    req(1, 2, 0, 6'h21, 32'hFFFFFFFF, d, e);
    chk("t4_mis_st", 64'({e, d}), 64'h1_00000000);
    req(0, 2, 0, 6'h20, 0, d, e); chk("t4_keep", 64'(d), 64'h80013344);
    req(0, 1, 0, 6'h23, 0, d, e); chk("t4_mis_h", 64'(e), 64'd1);
    req(0, 3, 0, 6'h08, 0, d, e); chk("t4_sz3", 64'(e), 64'd1);

    req(1, 0, 0, 6'h31, 32'hFFFFFF7F, d, e);
    req(0, 2, 1, 6'h30, 0, d, e); chk("byte_st", 64'(d), 64'h00007F00);
    req(1, 2, 0, 6'h3C, 32'h12345678, d, e);
    req(0, 1, 1, 6'h3E, 0, d, e); chk("top_h", 64'(d), 64'h00001234);
    req(1, 1, 0, 6'h00, 32'hFFFF9ABC, d, e);
    req(0, 2, 0, 6'h00, 0, d, e); chk("w0", 64'(d), 64'h00009ABC);

    req(1, 2, 0, 6'h04, 32'hCAFEF00D, d, e);
    req(0, 2, 0, 6'h04, 0, d, e); chk("t5_ld", 64'(d), 64'hCAFEF00D);
    repeat (3) @(negedge clk);

    req(1, 2, 0, 6'h08, 32'h55AA55AA, d, e);
    req(0, 2, 0, 6'h08, 0, d, e);
    do_reset();
    wait_ready("clr_len2");
    req(0, 2, 0, 6'h08, 0, d, e); chk("t6_ld", 64'({e, d}), 64'h0);

    req64(1, 3, 0, 7'h08, 64'h0123456789ABCDEF, d64, ve);
    chk("d_st", 64'(ve), 64'h2);
    req64(0, 3, 0, 7'h08, 0, d64, ve);
    chk("d_ld", d64, 64'h0123456789ABCDEF);
    chk("d_ld_ve", 64'(ve), 64'h2);
    req64(0, 2, 0, 7'h08, 0, d64, ve);
    chk("d_sw", d64, 64'hFFFFFFFF89ABCDEF);
    req64(0, 1, 1, 7'h0E, 0, d64, ve);
    chk("d_uh", d64, 64'h0000000000000123);
    req64(0, 3, 0, 7'h0C, 0, d64, ve);
    chk("d_mis", d64, 64'h0);
    chk("d_mis_ve", 64'(ve), 64'h3);

    repeat (3) @(negedge clk);
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
